// File: rtl/sram_to_axi_master.sv
// sram_to_axi_master: bridges a simple request/response port onto AXI4
// using single-beat 64-bit transactions, one transaction in flight.
module sram_to_axi_master #(
   parameter logic [3:0] AXI_ID = 4'h0
) (
   input  logic        CLK,
   input  logic        RESETn,
   input  logic        REQ_VALID,
   output logic        REQ_READY,
   input  logic        REQ_WE,
   input  logic [31:0] REQ_ADDR,
   input  logic [63:0] REQ_WDATA,
   input  logic [7:0]  REQ_WSTRB,
   output logic        RSP_VALID,
   output logic [63:0] RSP_RDATA,
   output logic        RSP_ERR,
   output logic [3:0]  AWID,
   output logic [31:0] AWADDR,
   output logic [7:0]  AWLEN,
   output logic [2:0]  AWSIZE,
   output logic [1:0]  AWBURST,
   output logic        AWLOCK,
   output logic [3:0]  AWCACHE,
   output logic [2:0]  AWPROT,
   output logic        AWVALID,
   input  logic        AWREADY,
   output logic [63:0] WDATA,
   output logic [7:0]  WSTRB,
   output logic        WLAST,
   output logic        WVALID,
   input  logic        WREADY,
   input  logic [3:0]  BID,
   input  logic [1:0]  BRESP,
   input  logic        BVALID,
   output logic        BREADY,
   output logic [3:0]  ARID,
   output logic [31:0] ARADDR,
   output logic [7:0]  ARLEN,
   output logic [2:0]  ARSIZE,
   output logic [1:0]  ARBURST,
   output logic        ARLOCK,
   output logic [3:0]  ARCACHE,
   output logic [2:0]  ARPROT,
   output logic        ARVALID,
   input  logic        ARREADY,
   input  logic [3:0]  RID,
   input  logic [63:0] RDATA,
   input  logic [1:0]  RRESP,
   input  logic        RLAST,
   input  logic        RVALID,
   output logic        RREADY
);

   typedef enum logic [2:0] {
      IDLE, WR_REQ, WR_RESP, RD_REQ, RD_DATA, DONE
   } state_e;

   state_e      state_q, state_d;
   logic [28:0] addr_q, addr_d;
   logic [63:0] wdata_q, wdata_d;
   logic [7:0]  wstrb_q, wstrb_d;
   logic        aw_done_q, aw_done_d;
   logic        w_done_q, w_done_d;
   logic [63:0] rdata_q, rdata_d;
   logic        err_q, err_d;

   // IDs are never checked and the low address bits are dropped
   logic unused_sigs;
   assign unused_sigs = ^{BID, RID, REQ_ADDR[2:0]};

   always_ff @(posedge CLK or negedge RESETn) begin
      if (!RESETn) begin
         state_q   <= IDLE;
         addr_q    <= '0;
         wdata_q   <= '0;
         wstrb_q   <= '0;
         aw_done_q <= 1'b0;
         w_done_q  <= 1'b0;
         rdata_q   <= '0;
         err_q     <= 1'b0;
      end else begin
         state_q   <= state_d;
         addr_q    <= addr_d;
         wdata_q   <= wdata_d;
         wstrb_q   <= wstrb_d;
         aw_done_q <= aw_done_d;
         w_done_q  <= w_done_d;
         rdata_q   <= rdata_d;
         err_q     <= err_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      addr_d    = addr_q;
      wdata_d   = wdata_q;
      wstrb_d   = wstrb_q;
      aw_done_d = aw_done_q;
      w_done_d  = w_done_q;
      rdata_d   = rdata_q;
      err_d     = err_q;
      REQ_READY = 1'b0;
      RSP_VALID = 1'b0;
      AWVALID   = 1'b0;
      WVALID    = 1'b0;
      BREADY    = 1'b0;
      ARVALID   = 1'b0;
      RREADY    = 1'b0;
      unique case (state_q)
         IDLE: begin
            REQ_READY = 1'b1;
            if (REQ_VALID) begin
               addr_d  = REQ_ADDR[31:3];
               wdata_d = REQ_WDATA;
               wstrb_d = REQ_WSTRB;
               state_d = REQ_WE ? WR_REQ : RD_REQ;
            end
         end
         WR_REQ: begin
            AWVALID   = ~aw_done_q;
            WVALID    = ~w_done_q;
            // each channel retires on its own handshake
            aw_done_d = aw_done_q | AWREADY;
            w_done_d  = w_done_q | WREADY;
            if (aw_done_d && w_done_d) begin
               aw_done_d = 1'b0;
               w_done_d  = 1'b0;
               state_d   = WR_RESP;
            end
         end
         WR_RESP: begin
            BREADY = 1'b1;
            if (BVALID) begin
               err_d   = |BRESP;
               state_d = DONE;
            end
         end
         RD_REQ: begin
            ARVALID = 1'b1;
            if (ARREADY) state_d = RD_DATA;
         end
         RD_DATA: begin
            RREADY = 1'b1;
            if (RVALID) begin
               rdata_d = RDATA;
               err_d   = (|RRESP) | ~RLAST;
               state_d = DONE;
            end
         end
         DONE: begin
            RSP_VALID = 1'b1;
            state_d   = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   assign AWID      = AXI_ID;
   assign AWADDR    = {addr_q, 3'b000};
   assign AWLEN     = 8'd0;
   assign AWSIZE    = 3'd3;
   assign AWBURST   = 2'b01;
   assign AWLOCK    = 1'b0;
   assign AWCACHE   = 4'd0;
   assign AWPROT    = 3'd0;
   assign WDATA     = wdata_q;
   assign WSTRB     = wstrb_q;
   assign WLAST     = 1'b1;
   assign ARID      = AXI_ID;
   assign ARADDR    = {addr_q, 3'b000};
   assign ARLEN     = 8'd0;
   assign ARSIZE    = 3'd3;
   assign ARBURST   = 2'b01;
   assign ARLOCK    = 1'b0;
   assign ARCACHE   = 4'd0;
   assign ARPROT    = 3'd0;
   assign RSP_RDATA = rdata_q;
   assign RSP_ERR   = err_q;

endmodule

// File: tb/tb_sram_to_axi_master.sv
// tb_sram_to_axi_master: randomized AXI slave plus a transaction-level
// model of the bridge; protocol and response checks run every cycle.
module tb_sram_to_axi_master;

   logic        CLK, RESETn;
   logic        REQ_VALID, REQ_READY, REQ_WE;
   logic [31:0] REQ_ADDR;
   logic [63:0] REQ_WDATA;
   logic [7:0]  REQ_WSTRB;
   logic        RSP_VALID, RSP_ERR;
   logic [63:0] RSP_RDATA;
   logic [3:0]  AWID, AWCACHE, ARID, ARCACHE, BID, RID;
   logic [31:0] AWADDR, ARADDR;
   logic [7:0]  AWLEN, ARLEN, WSTRB;
   logic [2:0]  AWSIZE, AWPROT, ARSIZE, ARPROT;
   logic [1:0]  AWBURST, ARBURST, BRESP, RRESP;
   logic        AWLOCK, AWVALID, AWREADY, ARLOCK, ARVALID, ARREADY;
   logic [63:0] WDATA, RDATA;
   logic        WLAST, WVALID, WREADY, BVALID, BREADY;
   logic        RLAST, RVALID, RREADY;

   sram_to_axi_master #(.AXI_ID(4'h5)) dut (
      .CLK(CLK), .RESETn(RESETn),
      .REQ_VALID(REQ_VALID), .REQ_READY(REQ_READY), .REQ_WE(REQ_WE),
      .REQ_ADDR(REQ_ADDR), .REQ_WDATA(REQ_WDATA), .REQ_WSTRB(REQ_WSTRB),
      .RSP_VALID(RSP_VALID), .RSP_RDATA(RSP_RDATA), .RSP_ERR(RSP_ERR),
      .AWID(AWID), .AWADDR(AWADDR), .AWLEN(AWLEN), .AWSIZE(AWSIZE),
      .AWBURST(AWBURST), .AWLOCK(AWLOCK), .AWCACHE(AWCACHE),
      .AWPROT(AWPROT), .AWVALID(AWVALID), .AWREADY(AWREADY),
      .WDATA(WDATA), .WSTRB(WSTRB), .WLAST(WLAST), .WVALID(WVALID),
      .WREADY(WREADY), .BID(BID), .BRESP(BRESP), .BVALID(BVALID),
      .BREADY(BREADY), .ARID(ARID), .ARADDR(ARADDR), .ARLEN(ARLEN),
      .ARSIZE(ARSIZE), .ARBURST(ARBURST), .ARLOCK(ARLOCK),
      .ARCACHE(ARCACHE), .ARPROT(ARPROT), .ARVALID(ARVALID),
      .ARREADY(ARREADY), .RID(RID), .RDATA(RDATA), .RRESP(RRESP),
      .RLAST(RLAST), .RVALID(RVALID), .RREADY(RREADY)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   typedef struct {
      logic        we;
      logic [31:0] addr;
      logic [63:0] wdata;
      logic [7:0]  wstrb;
      logic        err;
      logic [63:0] rdata;
   } txn_t;

   int n_chk = 0;
   int n_bad = 0;

   txn_t        cur;
   bit          cur_v = 0;
   logic [63:0] mdl_rdata = '0;
   int          lat, exp_lat, rsp_cnt = 0, acc_cnt = 0, w_beats;
   bit          hold_req = 0;

   int          aw_dly, w_dly, b_dly, ar_dly, r_dly;
   int          aw_cnt, w_cnt, b_cnt, ar_cnt, r_cnt;
   logic [1:0]  bresp_c, rresp_c;
   logic        rlast_c;
   logic [63:0] rdata_c;
   bit          aw_hs, w_hs, ar_hs, b_hs, r_hs;

   logic        s_awv, s_awr, s_wv, s_wr, s_bv, s_br;
   logic        s_arv, s_arr, s_rv, s_rr, s_reqv, s_reqr;
   logic [31:0] s_awaddr, s_araddr, s_raddr;
   logic [63:0] s_wdata, s_rwdata;
   logic [7:0]  s_wstrb, s_rwstrb;
   logic        s_wlast, s_rwe;

   task automatic chk(input string tag, input logic [127:0] got,
                      input logic [127:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic cfg(input int a, input int w, input int b,
                      input int ar, input int r,
                      input logic [1:0] br, input logic [1:0] rr,
                      input logic rl, input logic [63:0] rd);
      aw_dly = a; w_dly = w; b_dly = b; ar_dly = ar; r_dly = r;
      bresp_c = br; rresp_c = rr; rlast_c = rl; rdata_c = rd;
   endtask

   task automatic clear_slave();
      AWREADY = 0; WREADY = 0; BVALID = 0; ARREADY = 0; RVALID = 0;
      BRESP = 0; BID = 0; RDATA = 0; RRESP = 0; RLAST = 0; RID = 0;
      aw_hs = 0; w_hs = 0; ar_hs = 0; b_hs = 0; r_hs = 0;
      aw_cnt = 0; w_cnt = 0; b_cnt = 0; ar_cnt = 0; r_cnt = 0;
      w_beats = 0;
   endtask

   // One clock: snapshot what the rising edge will see, then at the
   // falling edge retire handshakes, check outputs and drive the slave.
   task automatic step();
      s_awv = AWVALID; s_awr = AWREADY; s_awaddr = AWADDR;
      s_wv = WVALID; s_wr = WREADY; s_wdata = WDATA;
      s_wstrb = WSTRB; s_wlast = WLAST;
      s_bv = BVALID; s_br = BREADY;
      s_arv = ARVALID; s_arr = ARREADY; s_araddr = ARADDR;
      s_rv = RVALID; s_rr = RREADY;
      s_reqv = REQ_VALID; s_reqr = REQ_READY; s_rwe = REQ_WE;
      s_raddr = REQ_ADDR; s_rwdata = REQ_WDATA; s_rwstrb = REQ_WSTRB;
      @(negedge CLK);

      if (s_reqv && s_reqr) begin
         chk("one_outstanding", 128'(cur_v), 128'(0));
         cur_v = 1; acc_cnt++;
         cur.we = s_rwe; cur.addr = s_raddr;
         cur.wdata = s_rwdata; cur.wstrb = s_rwstrb;
         cur.err = s_rwe ? (bresp_c != 2'b00)
                         : ((rresp_c != 2'b00) || !rlast_c);
         cur.rdata = s_rwe ? mdl_rdata : rdata_c;
         lat = 0;
         clear_slave();
         if (!hold_req) REQ_VALID = 0;
         if (cur.we) chk("aw_w_together", 128'({AWVALID, WVALID}),
                         128'(2'b11));
      end
      if (s_awv && s_awr) begin
         chk("awaddr", 128'(s_awaddr), 128'({cur.addr[31:3], 3'b000}));
         chk("aw_attr",
             128'({AWID, AWLEN, AWSIZE, AWBURST, AWLOCK, AWCACHE, AWPROT}),
             128'({4'h5, 8'd0, 3'd3, 2'b01, 1'b0, 4'd0, 3'd0}));
         aw_hs = 1;
      end
      if (s_wv && s_wr) begin
         w_beats++;
         chk("wdata", 128'(s_wdata), 128'(cur.wdata));
         chk("wstrb_wlast", 128'({s_wstrb, s_wlast}),
             128'({cur.wstrb, 1'b1}));
         w_hs = 1;
      end
      if (s_arv && s_arr) begin
         chk("araddr", 128'(s_araddr), 128'({cur.addr[31:3], 3'b000}));
         chk("ar_attr",
             128'({ARID, ARLEN, ARSIZE, ARBURST, ARLOCK, ARCACHE, ARPROT}),
             128'({4'h5, 8'd0, 3'd3, 2'b01, 1'b0, 4'd0, 3'd0}));
         ar_hs = 1;
      end
      if (s_bv && s_br) begin BVALID = 0; b_hs = 1; end
      if (s_rv && s_rr) begin RVALID = 0; r_hs = 1; end

      if (s_awv && !s_awr)
         chk("aw_hold", 128'({AWVALID, AWADDR}), 128'({1'b1, s_awaddr}));
      if (s_wv && !s_wr)
         chk("w_hold", 128'({WVALID, WDATA, WSTRB}),
             128'({1'b1, s_wdata, s_wstrb}));
      if (s_arv && !s_arr)
         chk("ar_hold", 128'({ARVALID, ARADDR}), 128'({1'b1, s_araddr}));
      if (aw_hs && AWVALID) chk("aw_dropped", 128'(AWVALID), 128'(0));
      if (w_hs && WVALID) chk("w_dropped", 128'(WVALID), 128'(0));
      if (BREADY)
         chk("bready_phase", 128'(cur_v && cur.we && aw_hs && w_hs && !b_hs),
             128'(1));
      if (RREADY)
         chk("rready_phase", 128'(cur_v && !cur.we && ar_hs && !r_hs),
             128'(1));

      lat++;
      if (RSP_VALID) begin
         chk("rsp_expected", 128'(cur_v), 128'(1));
         if (cur_v) begin
            chk("rsp_rdata", 128'(RSP_RDATA), 128'(cur.rdata));
            chk("rsp_err", 128'(RSP_ERR), 128'(cur.err));
            if (exp_lat > 0) chk("latency", 128'(lat), 128'(exp_lat));
            if (cur.we) chk("w_beats", 128'(w_beats), 128'(1));
            mdl_rdata = cur.rdata;
            cur_v = 0;
            rsp_cnt++;
         end
      end
      if (REQ_READY) chk("ready_idle", 128'(cur_v), 128'(0));

      if (AWVALID) begin AWREADY = (aw_cnt >= aw_dly); aw_cnt++; end
      else AWREADY = 0;
      if (WVALID) begin WREADY = (w_cnt >= w_dly); w_cnt++; end
      else WREADY = 0;
      if (ARVALID) begin ARREADY = (ar_cnt >= ar_dly); ar_cnt++; end
      else ARREADY = 0;
      if (aw_hs && w_hs && !b_hs && !BVALID) begin
         if (b_cnt >= b_dly) begin
            BVALID = 1; BRESP = bresp_c; BID = 4'($urandom);
         end
         b_cnt++;
      end
      if (ar_hs && !r_hs && !RVALID) begin
         if (r_cnt >= r_dly) begin
            RVALID = 1; RDATA = rdata_c; RRESP = rresp_c;
            RLAST = rlast_c; RID = 4'($urandom);
         end
         r_cnt++;
      end
   endtask

   task automatic do_txn(input logic we, input logic [31:0] a,
                         input logic [63:0] d, input logic [7:0] s,
                         input int elat);
      int n;
      n = rsp_cnt;
      REQ_WE = we; REQ_ADDR = a; REQ_WDATA = d; REQ_WSTRB = s;
      REQ_VALID = 1; exp_lat = elat;
      for (int i = 0; i < 200 && rsp_cnt == n; i++) step();
      chk("rsp_arrived", 128'(rsp_cnt), 128'(n + 1));
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      RESETn = 0; REQ_VALID = 0; REQ_WE = 0; REQ_ADDR = 0;
      REQ_WDATA = 0; REQ_WSTRB = 0; exp_lat = 0; lat = 0;
      clear_slave();
      cfg(0, 0, 0, 0, 0, 2'b00, 2'b00, 1'b1, 64'h0);
      #12;
      chk("reset_ready", 128'(REQ_READY), 128'(1));
      chk("reset_valids",
          128'({RSP_VALID, AWVALID, WVALID, ARVALID, BREADY, RREADY}),
          128'(0));
      chk("reset_rsp", 128'({RSP_RDATA, RSP_ERR}), 128'(0));
      @(negedge CLK);
      RESETn = 1;

      // zero-wait write
      do_txn(1, 32'h1004, 64'hA5A5_0000_1234_5678, 8'hFF, 3);
      // W accepted two cycles before AW
      cfg(2, 0, 0, 0, 0, 2'b00, 2'b00, 1'b1, 64'h0);
      do_txn(1, 32'h0000_3018, 64'h0123_4567_89AB_CDEF, 8'h0F, 5);
      // read with four wait cycles on R
      cfg(0, 0, 0, 0, 4, 2'b00, 2'b00, 1'b1, 64'hDEAD_BEEF_CAFE_F00D);
      do_txn(0, 32'h2000, 64'h0, 8'h0, 7);
      // zero-wait read with SLVERR, then clean write keeps read data
      cfg(0, 0, 0, 0, 0, 2'b00, 2'b10, 1'b1, 64'h1111_2222_3333_4444);
      do_txn(0, 32'h2008, 64'h0, 8'h0, 3);
      cfg(0, 0, 0, 0, 0, 2'b00, 2'b00, 1'b1, 64'h0);
      do_txn(1, 32'h2010, 64'h5555_6666_7777_8888, 8'hAA, 3);
      // missing RLAST flags an error
      cfg(1, 0, 0, 1, 0, 2'b00, 2'b00, 1'b0, 64'h9999_0000_AAAA_BBBB);
      do_txn(0, 32'h4444, 64'h0, 8'h0, 4);

      // request held high across four back-to-back writes
      begin
         int n0, a0;
         cfg(0, 0, 0, 0, 0, 2'b00, 2'b00, 1'b1, 64'h0);
         n0 = rsp_cnt; a0 = acc_cnt;
         hold_req = 1; exp_lat = 3;
         REQ_WE = 1; REQ_ADDR = 32'h0000_8000;
         REQ_WDATA = 64'hFEED_FACE_0000_0001; REQ_WSTRB = 8'hC3;
         REQ_VALID = 1;
         for (int i = 0; i < 100 && rsp_cnt < n0 + 4; i++) step();
         REQ_VALID = 0; hold_req = 0;
         chk("held_rsp_count", 128'(rsp_cnt - n0), 128'(4));
         chk("held_accepts", 128'(acc_cnt - a0), 128'(4));
         step(); step();
      end

      // randomized traffic
      for (int k = 0; k < 40; k++) begin
         int a, w, b, ar, r, el;
         logic we;
         logic [1:0] br, rr;
         a = $urandom_range(0, 3); w = $urandom_range(0, 3);
         b = $urandom_range(0, 3); ar = $urandom_range(0, 3);
         r = $urandom_range(0, 3);
         we = 1'($urandom_range(0, 1));
         br = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
         rr = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
         cfg(a, w, b, ar, r, br, rr, ($urandom_range(0, 7) != 0),
             {$urandom, $urandom});
         el = we ? (((a > w) ? a : w) + b + 3) : (ar + r + 3);
         do_txn(we, $urandom, {$urandom, $urandom}, 8'($urandom), el);
      end

      // reset while waiting for read data
      cfg(0, 0, 0, 0, 30, 2'b00, 2'b00, 1'b1, 64'h0);
      REQ_WE = 0; REQ_ADDR = 32'h0000_6000; REQ_VALID = 1; exp_lat = 0;
      for (int i = 0; i < 20 && !RREADY; i++) step();
      chk("reached_rd_data", 128'(RREADY), 128'(1));
      #2;
      RESETn = 0;
      #1;
      chk("rst_rready", 128'(RREADY), 128'(0));
      chk("rst_rsp_valid", 128'(RSP_VALID), 128'(0));
      chk("rst_rsp_clear", 128'({RSP_RDATA, RSP_ERR}), 128'(0));
      REQ_VALID = 0; cur_v = 0; mdl_rdata = '0;
      clear_slave();
      @(negedge CLK);
      @(negedge CLK);
      RESETn = 1;
      step();
      chk("rst_release_ready", 128'(REQ_READY), 128'(1));
      for (int i = 0; i < 5; i++) step();

      // normal operation after the abandoned read
      cfg(0, 0, 0, 0, 0, 2'b00, 2'b00, 1'b1, 64'h7777_0000_1234_0000);
      do_txn(0, 32'h0000_6008, 64'h0, 8'h0, 3);

      $display("test done: total=%0d bad=%0d", n_chk, n_bad);
      $finish;
   end

endmodule

// File: doc/sram_to_axi_master.md
SRAM_TO_AXI_MASTER -- requirements
Module: sram_to_axi_master

Interface
REQ-001 The block SHALL have parameter AXI_ID, default 4'h0, giving the constant AWID/ARID value.
REQ-002 The block SHALL have the port CLK, input, 1 bit: the single clock; all logic is rising-edge.
REQ-003 The block SHALL have the port RESETn, input, 1 bit: asynchronous active-low reset.
REQ-004 The block SHALL have the port REQ_VALID, input, 1 bit: a request is present.
REQ-005 The block SHALL have the port REQ_READY, output, 1 bit: the request is accepted when high together with REQ_VALID.
REQ-006 The block SHALL have the ports REQ_WE (input, 1), REQ_ADDR (input, 32), REQ_WDATA (input, 64) and REQ_WSTRB (input, 8): write flag, byte address, write data and byte enables.
REQ-007 The block SHALL have the ports RSP_VALID (output, 1), RSP_RDATA (output, 64) and RSP_ERR (output, 1): completion pulse, read data and error flag.
REQ-008 The block SHALL have the AXI write ports AWID[3:0], AWADDR[31:0], AWLEN[7:0], AWSIZE[2:0], AWBURST[1:0], AWLOCK, AWCACHE[3:0], AWPROT[2:0] and AWVALID as outputs, and AWREADY as an input.
REQ-009 The block SHALL have WDATA[63:0], WSTRB[7:0], WLAST and WVALID as outputs, and WREADY as an input.
REQ-010 The block SHALL have BID[3:0], BRESP[1:0] and BVALID as inputs, and BREADY as an output.
REQ-011 The block SHALL have the AR channel mirroring AW (ARID..ARPROT, ARVALID as outputs; ARREADY as an input).
REQ-012 The block SHALL have RID[3:0], RDATA[63:0], RRESP[1:0], RLAST and RVALID as inputs, and RREADY as an output.

Function
REQ-013 The block SHALL issue only single-beat transactions: xLEN=0, xSIZE=3, xBURST=INCR(01), xLOCK=0, xCACHE=0, xPROT=0, xID=AXI_ID, WLAST=1.
REQ-014 The block SHALL drive xADDR as {captured REQ_ADDR[31:3], 3'b000}.
REQ-015 The block SHALL implement states IDLE, WR_REQ, WR_RESP, RD_REQ, RD_DATA and DONE.
REQ-016 REQ_READY SHALL be high only in IDLE; on acceptance the block SHALL register the address, data, strobe and WE, and then go to WR_REQ if WE=1 or to RD_REQ if WE=0.
REQ-017 In WR_REQ the block SHALL assert AWVALID and WVALID in the same cycle, and SHALL drop each one independently after its own handshake.
REQ-018 The block SHALL go from WR_REQ to WR_RESP once both the AW and W handshakes have completed, including when they complete in the same cycle or in either order.
REQ-019 Once asserted, AWVALID, WVALID and ARVALID SHALL NOT deassert before their handshake, and their payload SHALL stay stable.
REQ-020 In WR_RESP the block SHALL assert BREADY, and on BVALID it SHALL capture RSP_ERR=(BRESP!=2'b00) and go to DONE.
REQ-021 In RD_REQ the block SHALL assert ARVALID, and on ARREADY it SHALL go to RD_DATA.
REQ-022 In RD_DATA the block SHALL assert RREADY, and on RVALID it SHALL capture RDATA, set RSP_ERR=(RRESP!=2'b00)|~RLAST, and go to DONE.
REQ-023 In DONE the block SHALL hold RSP_VALID high for exactly one cycle, then return to IDLE.
REQ-024 RSP_VALID SHALL have no backpressure.
REQ-025 RSP_RDATA and RSP_ERR SHALL hold their values until the next completion.
REQ-026 For writes, RSP_RDATA SHALL be left unchanged.
REQ-027 BREADY and RREADY SHALL be low outside WR_RESP and RD_DATA respectively.
REQ-028 BID and RID SHALL NOT be checked.
REQ-029 With zero-wait responses, latency from request acceptance to RSP_VALID SHALL be 3 cycles for a write (WR_REQ, WR_RESP, DONE).
REQ-030 With zero-wait responses, latency for a read SHALL be 3 cycles (RD_REQ, RD_DATA, DONE).
REQ-031 The block SHALL have only one outstanding transaction, and the next request SHALL be accepted no earlier than the cycle after DONE.

Reset
REQ-032 While RESETn=0 the block SHALL immediately force the state to IDLE and clear all AW/W/AR valids, BREADY, RREADY, RSP_VALID, RSP_ERR, RSP_RDATA and the handshake-done flags, independent of CLK.
REQ-033 Deassertion of RESETn SHALL be sampled synchronously.
REQ-034 A reset mid-transaction SHALL abandon that transaction with no RSP_VALID.

Verification
REQ-035 The bench SHALL cover: write addr 0x1004, data 0xA5A5_0000_1234_5678, strobe 0xFF, AWREADY=WREADY=BVALID=1 -> AWADDR=0x1000, WLAST=1, RSP_VALID 3 cycles after accept, RSP_ERR=0.
REQ-036 The bench SHALL cover: write with WREADY high 2 cycles before AWREADY -> WVALID drops after its handshake, AWVALID held, exactly one W beat, one RSP_VALID.
REQ-037 The bench SHALL cover: read addr 0x2000, R returns 0xDEAD_BEEF_CAFE_F00D, RRESP=00, RLAST=1 after 4 wait cycles -> RSP_RDATA=0xDEAD_BEEF_CAFE_F00D, RSP_ERR=0.
REQ-038 The bench SHALL cover: read returning RRESP=2'b10 -> RSP_ERR=1; a following write with BRESP=00 -> RSP_ERR=0.
REQ-039 The bench SHALL cover: RESETn low while in RD_DATA -> RREADY and RSP_VALID=0 immediately, REQ_READY=1 on the first edge after release.
REQ-040 The bench SHALL cover: REQ_VALID held high continuously -> REQ_READY pulses once per transaction, never while busy.
